// File: rtl/usb_desc_streamer_if.sv
// rtl/usb_desc_streamer_if.sv - request, descriptor-read and IN-stream signals of the descriptor streamer
// Purpose: bundles every handshake/bus signal of usb_desc_streamer; clk and rst stay plain ports.
// Modports:
//   master - the streamer: drives req_ready, desc_addr, tx_*, busy, done
//   slave  - the environment: request decoder, descriptor ROM and transaction layer
interface usb_desc_streamer_if;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_wlength;
    logic [15:0] desc_len;
    logic [15:0] desc_addr;
    logic [7:0]  desc_data;
    logic        in_tok;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  tx_data;
    logic        tx_last;
    logic        tx_zlp;
    logic        pkt_ack;
    logic        pkt_retry;
    logic        abort;
    logic        busy;
    logic        done;

    modport master (
        input  req_valid, req_wlength, desc_len, desc_data, in_tok, tx_ready,
               pkt_ack, pkt_retry, abort,
        output req_ready, desc_addr, tx_valid, tx_data, tx_last, tx_zlp, busy, done
    );

    modport slave (
        output req_valid, req_wlength, desc_len, desc_data, in_tok, tx_ready,
               pkt_ack, pkt_retry, abort,
        input  req_ready, desc_addr, tx_valid, tx_data, tx_last, tx_zlp, busy, done
    );
endinterface

// File: rtl/usb_desc_streamer.sv
// rtl/usb_desc_streamer.sv - GET_DESCRIPTOR IN data stage sequencer and packetiser
// Purpose: fetches descriptor bytes by address and cuts them into MAXPKT-byte IN packets,
//   truncating to wLength, appending a terminating ZLP when needed, replaying a packet on
//   retry and cancelling on abort (new SETUP).
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - usb_desc_streamer_if.master: req_valid/req_ready/req_wlength/desc_len request,
//          desc_addr/desc_data descriptor read, in_tok, tx_valid/tx_ready/tx_data/tx_last/tx_zlp
//          beat stream, pkt_ack/pkt_retry/abort host outcome, busy and done status
// Parameter: MAXPKT - bytes per data packet (8/16/32/64)
module usb_desc_streamer #(
    parameter int MAXPKT = 8
) (
    input  logic               clk,
    input  logic               rst,
    usb_desc_streamer_if.master bus
);
    typedef enum logic [1:0] {IDLE, WAIT_IN, SEND, WAIT_ACK} state_t;

    localparam logic [15:0] MAX_PKT16 = 16'(MAXPKT);

    state_t      state;
    state_t      stateNext;
    logic [15:0] total;
    logic [15:0] base;
    logic [15:0] descAddr;
    logic [6:0]  pktLen;
    logic        needZlp;

    logic [15:0] reqTotal;
    logic [15:0] remaining;
    logic [6:0]  nextLen;
    logic [15:0] beatIdx;
    logic        isZlp;
    logic        lastBeat;
    logic        finish;
    logic        aborting;

    assign reqTotal  = (bus.req_wlength < bus.desc_len) ? bus.req_wlength : bus.desc_len;
    assign remaining = total - base;
    // remaining is below MAXPKT (<= 64) whenever the low bits are used, so 7 bits suffice
    assign nextLen   = (remaining >= MAX_PKT16) ? 7'(MAXPKT) : remaining[6:0];
    assign isZlp     = (pktLen == 7'd0);
    // Beat position is derived from the address so a retry only has to rewind descAddr
    assign beatIdx   = descAddr - base;
    assign lastBeat  = isZlp || (beatIdx == 16'(pktLen) - 16'd1);
    // The transfer ends once all bytes are acked, unless a ZLP is still owed; the owed ZLP
    // is itself the len==0 packet, so its ack always finishes
    assign finish    = ((base + 16'(pktLen)) == total) && (!needZlp || isZlp);
    assign aborting  = bus.abort && (state != IDLE);
    assign bus.desc_addr = descAddr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext     = state;
        bus.req_ready = 1'b0;
        bus.busy      = 1'b1;
        bus.tx_valid  = 1'b0;
        bus.tx_data   = 8'h00;
        bus.tx_last   = 1'b0;
        bus.tx_zlp    = 1'b0;
        bus.done      = 1'b0;
        case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                bus.busy      = 1'b0;
                if (bus.req_valid) begin
                    stateNext = WAIT_IN;
                end
            end
            WAIT_IN: begin
                if (bus.in_tok) begin
                    stateNext = SEND;
                end
            end
            SEND: begin
                bus.tx_valid = 1'b1;
                bus.tx_data  = isZlp ? 8'h00 : bus.desc_data;
                bus.tx_last  = lastBeat;
                bus.tx_zlp   = isZlp;
                if (bus.tx_ready && lastBeat) begin
                    stateNext = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (bus.pkt_ack) begin
                    stateNext = finish ? IDLE : WAIT_IN;
                    // Pulsed in the last busy cycle so it never overlaps the new req_ready
                    bus.done  = finish && !bus.abort;
                end else if (bus.pkt_retry) begin
                    stateNext = WAIT_IN;
                end
            end
            default: stateNext = IDLE;
        endcase
        if (aborting) begin
            stateNext = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            total    <= 16'd0;
            base     <= 16'd0;
            descAddr <= 16'd0;
            pktLen   <= 7'd0;
            needZlp  <= 1'b0;
        end else if (aborting) begin
            total    <= 16'd0;
            base     <= 16'd0;
            descAddr <= 16'd0;
            pktLen   <= 7'd0;
            needZlp  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        total    <= reqTotal;
                        base     <= 16'd0;
                        descAddr <= 16'd0;
                        // MAXPKT is a power of two, so the modulo is a mask
                        needZlp  <= (reqTotal < bus.req_wlength) &&
                                    ((reqTotal & (MAX_PKT16 - 16'd1)) == 16'd0);
                    end
                end
                WAIT_IN: begin
                    if (bus.in_tok) begin
                        pktLen <= nextLen;
                    end
                end
                SEND: begin
                    if (bus.tx_ready && !isZlp) begin
                        descAddr <= descAddr + 16'd1;
                    end
                end
                WAIT_ACK: begin
                    if (bus.pkt_ack) begin
                        base <= base + 16'(pktLen);
                    end else if (bus.pkt_retry) begin
                        descAddr <= base;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
